// File: rtl/config_reporter_pkg.sv
// -----------------------------------------------------------------------------
// config_reporter_pkg
// Shared constants for the configuration reporter: FSM state encodings,
// default frame header, frame length in bytes, serial bits per byte, and the
// even-parity helper used by the byte serializer.
// -----------------------------------------------------------------------------
package config_reporter_pkg;

  // FSM state encodings (also exported on db_estado)
  localparam logic [2:0] ST_INICIAL   = 3'd0;
  localparam logic [2:0] ST_CAPTURA   = 3'd1;
  localparam logic [2:0] ST_CARREGA   = 3'd2;
  localparam logic [2:0] ST_TRANSMITE = 3'd3;
  localparam logic [2:0] ST_ESPERA    = 3'd4;
  localparam logic [2:0] ST_PROXIMO   = 3'd5;
  localparam logic [2:0] ST_FIM       = 3'd6;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Header + 10 data bytes + checksum
  localparam int FRAME_BYTES = 12;

  // Start + 8 data + parity + stop
  localparam int SERIAL_BITS = 11;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/tx_serial_8E1.sv
// -----------------------------------------------------------------------------
// tx_serial_8E1
// Serializes one byte as 8E1: start bit (0), 8 data bits LSB first, even
// parity bit, stop bit (1). Every bit lasts CLKS_PER_BIT clock cycles.
//
// Ports
//   clock         system clock
//   reset         asynchronous active-low reset
//   partida       start request, accepted only while idle
//   dados[7:0]    byte to send, sampled together with partida
//   saida_serial  serial line, idle high
//   pronto        one-cycle pulse near the end of the stop bit
// -----------------------------------------------------------------------------
module tx_serial_8E1
  import config_reporter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [7:0] dados,
  output logic       saida_serial,
  output logic       pronto
);

  localparam int                BAUD_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_EARLY = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]        BIT_LAST   = 4'(SERIAL_BITS - 1);

  logic              active;
  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_idx;    // bit currently on the line, 0 = start bit
  logic [9:0]        frame_bits; // bits following the start bit: data, parity, stop

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active       <= 1'b0;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      frame_bits   <= '0;
      saida_serial <= 1'b1;
    end else if (!active) begin
      saida_serial <= 1'b1;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      if (partida) begin
        active       <= 1'b1;
        frame_bits   <= {1'b1, even_parity(dados), dados};
        saida_serial <= 1'b0;
      end
    end else if (baud_cnt == BAUD_LAST) begin
      baud_cnt <= '0;
      if (bit_idx == BIT_LAST) begin
        active       <= 1'b0;
        saida_serial <= 1'b1;
      end else begin
        bit_idx      <= bit_idx + 4'd1;
        // frame_bits[k] is serial bit k+1, so the current index selects the next bit
        saida_serial <= frame_bits[bit_idx];
      end
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  // Fired one cycle before the stop bit ends: the caller needs three cycles
  // (next-index, load, start) before the serializer sees partida again, so the
  // early pulse keeps the idle gap between consecutive bytes at two cycles.
  assign pronto = active && (bit_idx == BIT_LAST) && (baud_cnt == BAUD_EARLY);

endmodule

// File: rtl/config_reporter.sv
// -----------------------------------------------------------------------------
// config_reporter
// On request, snapshots five 16-bit limits and sends them on a serial line as a
// 12-byte frame: HEADER, humidity MSB/LSB, temp1..temp4 MSB/LSB, XOR checksum
// of the ten data bytes. Requests arriving while a report is in flight are
// ignored.
//
// Ports
//   clock           system clock
//   reset           asynchronous active-low reset
//   enviar_config   report request, level-sampled in INICIAL
//   umidade_lim_in  humidity limit
//   temp_lim1_in .. temp_lim4_in  temperature limits
//   tx_serial       serial line, idle high
//   ocupado         high while a report is in progress
//   pronto_envio    one-cycle pulse when the frame completes
//   db_estado       current FSM state
// -----------------------------------------------------------------------------
module config_reporter
  import config_reporter_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enviar_config,
  input  logic [15:0] umidade_lim_in,
  input  logic [15:0] temp_lim1_in,
  input  logic [15:0] temp_lim2_in,
  input  logic [15:0] temp_lim3_in,
  input  logic [15:0] temp_lim4_in,
  output logic        tx_serial,
  output logic        ocupado,
  output logic        pronto_envio,
  output logic [2:0]  db_estado
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

  logic [2:0]  state, next_state;
  logic [3:0]  byte_idx;
  logic [15:0] snap_umid, snap_t1, snap_t2, snap_t3, snap_t4;
  logic [7:0]  checksum;
  logic [7:0]  byte_sel, byte_q;
  logic        byte_done;

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_INICIAL:   if (enviar_config) next_state = ST_CAPTURA;
      ST_CAPTURA:   next_state = ST_CARREGA;
      ST_CARREGA:   next_state = ST_TRANSMITE;
      ST_TRANSMITE: next_state = ST_ESPERA;
      ST_ESPERA:    if (byte_done) next_state = ST_PROXIMO;
      ST_PROXIMO:   next_state = (byte_idx < LAST_IDX) ? ST_CARREGA : ST_FIM;
      ST_FIM:       next_state = ST_INICIAL;
      default:      next_state = ST_INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_INICIAL;
    else        state <= next_state;
  end

  // Snapshot, checksum, byte register and index
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snap_umid <= '0;
      snap_t1   <= '0;
      snap_t2   <= '0;
      snap_t3   <= '0;
      snap_t4   <= '0;
      checksum  <= '0;
      byte_q    <= '0;
      byte_idx  <= '0;
    end else begin
      // Tracks the snapshot with one cycle of lag; the snapshot only changes
      // in CAPTURA, so it is settled long before byte 11 is loaded.
      checksum <= snap_umid[15:8] ^ snap_umid[7:0] ^ snap_t1[15:8] ^ snap_t1[7:0]
                ^ snap_t2[15:8]   ^ snap_t2[7:0]   ^ snap_t3[15:8] ^ snap_t3[7:0]
                ^ snap_t4[15:8]   ^ snap_t4[7:0];
      case (state)
        ST_CAPTURA: begin
          snap_umid <= umidade_lim_in;
          snap_t1   <= temp_lim1_in;
          snap_t2   <= temp_lim2_in;
          snap_t3   <= temp_lim3_in;
          snap_t4   <= temp_lim4_in;
          byte_idx  <= '0;
        end
        ST_CARREGA: byte_q <= byte_sel;
        ST_PROXIMO: if (byte_idx < LAST_IDX) byte_idx <= byte_idx + 4'd1;
        default: ;
      endcase
    end
  end

  // Frame byte selection
  always_comb begin
    byte_sel = checksum;
    case (byte_idx)
      4'd0:  byte_sel = HEADER;
      4'd1:  byte_sel = snap_umid[15:8];
      4'd2:  byte_sel = snap_umid[7:0];
      4'd3:  byte_sel = snap_t1[15:8];
      4'd4:  byte_sel = snap_t1[7:0];
      4'd5:  byte_sel = snap_t2[15:8];
      4'd6:  byte_sel = snap_t2[7:0];
      4'd7:  byte_sel = snap_t3[15:8];
      4'd8:  byte_sel = snap_t3[7:0];
      4'd9:  byte_sel = snap_t4[15:8];
      4'd10: byte_sel = snap_t4[7:0];
      default: byte_sel = checksum;
    endcase
  end

  tx_serial_8E1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clock       (clock),
    .reset       (reset),
    .partida     (state == ST_TRANSMITE),
    .dados       (byte_q),
    .saida_serial(tx_serial),
    .pronto      (byte_done)
  );

  assign ocupado      = (state != ST_INICIAL);
  assign pronto_envio = (state == ST_FIM);
  assign db_estado    = state;

endmodule

// File: tb/tb_config_reporter.sv
// -----------------------------------------------------------------------------
// tb_config_reporter
// Self-checking bench for config_reporter with CLKS_PER_BIT = 4. A line
// monitor decodes every 8E1 byte from tx_serial; decoded bytes are compared
// with frames built from the limit values by a behavioural model.
// -----------------------------------------------------------------------------
module tb_config_reporter;

  localparam int         CPB = 4;
  localparam logic [7:0] HDR = 8'hA5;

  logic        clock = 1'b0;
  logic        reset;
  logic        enviar_config;
  logic [15:0] umid, t1, t2, t3, t4;
  logic        tx_serial, ocupado, pronto_envio;
  logic [2:0]  db_estado;

  always #5 clock = ~clock;

  config_reporter #(
    .CLKS_PER_BIT(CPB),
    .HEADER      (HDR)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enviar_config (enviar_config),
    .umidade_lim_in(umid),
    .temp_lim1_in  (t1),
    .temp_lim2_in  (t2),
    .temp_lim3_in  (t3),
    .temp_lim4_in  (t4),
    .tx_serial     (tx_serial),
    .ocupado       (ocupado),
    .pronto_envio  (pronto_envio),
    .db_estado     (db_estado)
  );

  typedef struct {
    logic [7:0] data;
    bit         par_ok;
    bit         stop_ok;
    bit         glitch;
    int         gap;
  } rx_t;

  rx_t        rx_q[$];
  logic [7:0] exp_q[$];
  int         pron_cnt;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  // Line monitor: decodes bytes, checks each bit holds for exactly CPB cycles,
  // records the idle gap before each start bit. Aborts on reset.
  initial begin : line_monitor
    int   c;
    int   idle_run;
    logic bitv[11];
    bit   gl;
    rx_t  r;
    c = -1; idle_run = 0; pron_cnt = 0; gl = 0;
    r.data = '0; r.par_ok = 0; r.stop_ok = 0; r.glitch = 0; r.gap = 0;
    forever begin
      @(negedge clock);
      if (pronto_envio === 1'b1) pron_cnt++;
      if (reset !== 1'b1) begin
        c = -1; idle_run = 0;
      end else if (c < 0) begin
        if (tx_serial === 1'b0) begin
          c = 0; gl = 0; bitv[0] = 1'b0; r.gap = idle_run;
        end else begin
          idle_run++;
        end
      end else begin
        c++;
        if (c % CPB == 0) bitv[c / CPB] = tx_serial;
        else if (tx_serial !== bitv[c / CPB]) gl = 1;
        if (c == 11 * CPB - 1) begin
          for (int k = 0; k < 8; k++) r.data[k] = bitv[k + 1];
          r.par_ok  = ((^r.data) ^ bitv[9]) == 1'b0;
          r.stop_ok = (bitv[10] === 1'b1);
          r.glitch  = gl;
          rx_q.push_back(r);
          c = -1; idle_run = 0;
        end
      end
    end
  end

  // Reference model: expected frame bytes for a given set of limits
  task automatic model_frame(input logic [15:0] u, a, b, cc, d);
    logic [15:0] lims[5];
    logic [7:0]  cs;
    lims[0] = u; lims[1] = a; lims[2] = b; lims[3] = cc; lims[4] = d;
    cs = 8'h00;
    exp_q.push_back(HDR);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(lims[i][15:8]);
      exp_q.push_back(lims[i][7:0]);
      cs = cs ^ lims[i][15:8] ^ lims[i][7:0];
    end
    exp_q.push_back(cs);
  endtask

  task automatic set_limits(input logic [15:0] u, a, b, cc, d);
    umid = u; t1 = a; t2 = b; t3 = cc; t4 = d;
  endtask

  task automatic pulse_request();
    @(negedge clock) enviar_config = 1'b1;
    @(negedge clock) enviar_config = 1'b0;
  endtask

  task automatic wait_pronto(input int bound, input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (pronto_envio === 1'b1) begin ok = 1; break; end
    end
    check({tag, " frame done"}, 32'(ok), 1);
  endtask

  task automatic wait_rx(input int n, input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (rx_q.size() >= n) begin ok = 1; break; end
    end
    check({tag, " byte reached"}, 32'(ok), 1);
  endtask

  task automatic compare_frames(input string tag);
    int n;
    check({tag, " byte count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s byte%0d data", tag, i), 32'(rx_q[i].data), 32'(exp_q[i]));
      check($sformatf("%s byte%0d parity", tag, i), 32'(rx_q[i].par_ok), 1);
      check($sformatf("%s byte%0d stop", tag, i), 32'(rx_q[i].stop_ok), 1);
      check($sformatf("%s byte%0d bit timing", tag, i), 32'(rx_q[i].glitch), 0);
      if (i % 12 != 0)
        check($sformatf("%s byte%0d gap<=2", tag, i), 32'(rx_q[i].gap <= 2), 1);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int p0;
    int nlow;
    bit seen_low;
    logic [15:0] r[5];

    reset = 1'b0;
    enviar_config = 1'b0;
    set_limits(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clock);
    check("reset tx_serial", 32'(tx_serial), 1);
    check("reset ocupado", 32'(ocupado), 0);
    check("reset pronto_envio", 32'(pronto_envio), 0);
    check("reset db_estado", 32'(db_estado), 0);
    @(negedge clock) reset = 1'b1;
    repeat (5) @(negedge clock);
    check("idle db_estado", 32'(db_estado), 0);
    check("idle tx_serial", 32'(tx_serial), 1);

    // Nominal report
    set_limits(16'h0050, 16'h0019, 16'h001E, 16'h0023, 16'h0028);
    model_frame(umid, t1, t2, t3, t4);
    p0 = pron_cnt;
    @(negedge clock) enviar_config = 1'b1;
    @(negedge clock) enviar_config = 1'b0;
    check("capture state", 32'(db_estado), 1);
    check("busy after request", 32'(ocupado), 1);
    wait_pronto(2000, "nominal");
    repeat (4) @(negedge clock);
    check("nominal pronto pulses", 32'(pron_cnt - p0), 1);
    if (rx_q.size() == 12) check("nominal checksum", 32'(rx_q[11].data), 32'h5C);
    compare_frames("nominal");

    // Snapshot hold: limit changes mid-frame must not reach the frame
    model_frame(umid, t1, t2, t3, t4);
    pulse_request();
    wait_rx(2, "snapshot");
    t1 = 16'hFFFF;
    wait_pronto(2000, "snapshot");
    repeat (4) @(negedge clock);
    if (rx_q.size() == 12) begin
      check("snapshot t1 msb", 32'(rx_q[3].data), 32'h00);
      check("snapshot t1 lsb", 32'(rx_q[4].data), 32'h19);
      check("snapshot checksum", 32'(rx_q[11].data), 32'h5C);
    end
    compare_frames("snapshot");
    t1 = 16'h0019;

    // Request while busy is ignored
    model_frame(umid, t1, t2, t3, t4);
    p0 = pron_cnt;
    pulse_request();
    wait_rx(5, "busy");
    pulse_request();
    wait_pronto(2000, "busy");
    repeat (150) @(negedge clock);
    check("busy pronto pulses", 32'(pron_cnt - p0), 1);
    check("busy no restart", 32'(ocupado), 0);
    compare_frames("busy");

    // Parity edge case: all ones
    set_limits(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    model_frame(umid, t1, t2, t3, t4);
    pulse_request();
    wait_pronto(2000, "all_ones");
    repeat (4) @(negedge clock);
    if (rx_q.size() == 12) check("all_ones checksum", 32'(rx_q[11].data), 32'h00);
    compare_frames("all_ones");

    // Random limits
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < 5; k++) r[k] = 16'($urandom);
      set_limits(r[0], r[1], r[2], r[3], r[4]);
      model_frame(umid, t1, t2, t3, t4);
      pulse_request();
      wait_pronto(2000, $sformatf("rand%0d", it));
      repeat (4) @(negedge clock);
      compare_frames($sformatf("rand%0d", it));
    end

    // Reset in the middle of byte 7
    for (int k = 0; k < 5; k++) r[k] = 16'($urandom);
    set_limits(r[0], r[1], r[2], r[3], r[4]);
    pulse_request();
    wait_rx(7, "midreset");
    seen_low = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (tx_serial === 1'b0) begin seen_low = 1; break; end
    end
    check("midreset start bit seen", 32'(seen_low), 1);
    #2 reset = 1'b0;
    #1;
    check("midreset tx_serial", 32'(tx_serial), 1);
    check("midreset ocupado", 32'(ocupado), 0);
    check("midreset db_estado", 32'(db_estado), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    rx_q.delete();
    exp_q.delete();
    repeat (200) @(negedge clock);
    check("post-reset no bytes", 32'(rx_q.size()), 0);
    check("post-reset db_estado", 32'(db_estado), 0);
    check("post-reset tx_serial", 32'(tx_serial), 1);

    // Back-to-back reports with the request held high
    for (int k = 0; k < 5; k++) r[k] = 16'($urandom);
    set_limits(r[0], r[1], r[2], r[3], r[4]);
    model_frame(umid, t1, t2, t3, t4);
    model_frame(umid, t1, t2, t3, t4);
    p0 = pron_cnt;
    @(negedge clock) enviar_config = 1'b1;
    wait_pronto(2000, "b2b first");
    nlow = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (ocupado === 1'b1) break;
      nlow++;
    end
    check("b2b ocupado low cycles", 32'(nlow), 1);
    enviar_config = 1'b0;
    wait_pronto(2000, "b2b second");
    repeat (100) @(negedge clock);
    check("b2b pronto pulses", 32'(pron_cnt - p0), 2);
    check("b2b idle after", 32'(db_estado), 0);
    compare_frames("b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/config_reporter.md
CONFIG_REPORTER -- requirements
Module: config_reporter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (115200 baud at 50 MHz).
REQ-002 Parameter HEADER, default 8'hA5, frame start byte.
REQ-003 clock  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enviar_config  input  1  request to transmit the current limits; level-sampled each cycle.
REQ-006 umidade_lim_in  input  16  humidity limit to report.
REQ-007 temp_lim1_in, temp_lim2_in, temp_lim3_in, temp_lim4_in  input  16 each  temperature limits to report.
REQ-008 tx_serial  output  1  serial line, idle high.
REQ-009 ocupado  output  1  high while a report is in progress.
REQ-010 pronto_envio  output  1  one-cycle pulse when the report frame completes.
REQ-011 db_estado  output  3  current FSM state encoding, for debug.

Function
REQ-012 Report frame SHALL be 12 bytes in this order: HEADER, umidade MSB, umidade LSB, temp1 MSB, temp1 LSB, temp2 MSB/LSB, temp3 MSB/LSB, temp4 MSB/LSB, checksum.
REQ-013 Checksum SHALL be the bitwise XOR of the 10 data bytes; HEADER is excluded.
REQ-014 Each byte SHALL be sent as 11 bits: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1); each bit lasts exactly CLKS_PER_BIT cycles.
REQ-015 Bytes SHALL be sent back-to-back: the next start bit begins in the cycle after the previous stop bit ends, plus at most 2 cycles of FSM overhead.
REQ-016 FSM states SHALL be: INICIAL=0, CAPTURA=1, CARREGA=2, TRANSMITE=3, ESPERA=4, PROXIMO=5, FIM=6.
  - INICIAL -> CAPTURA when enviar_config=1.
  - CAPTURA -> CARREGA.
  - CARREGA -> TRANSMITE.
  - TRANSMITE -> ESPERA.
  - ESPERA -> PROXIMO on byte done.
  - PROXIMO -> CARREGA if byte index < 11, else FIM.
  - FIM -> INICIAL.
REQ-017 In CAPTURA, all five limits SHALL be registered into snapshot registers; input changes after that cycle SHALL NOT affect the frame in flight.
REQ-018 The checksum SHALL be computed from the snapshot registers and SHALL be ready before byte 11 is loaded.
REQ-019 ocupado SHALL be 1 in every state except INICIAL.
REQ-020 pronto_envio SHALL be 1 only in FIM, for exactly one cycle.
REQ-021 enviar_config SHALL be ignored while ocupado=1; no restart or queueing occurs.
REQ-022 If enviar_config is still high in the cycle after FIM, a new report SHALL start.
REQ-023 The byte index SHALL be 4 bits, run 0..11, and be cleared in CAPTURA; it SHALL never wrap past 11.
REQ-024 tx_serial SHALL be 1 in every state outside an active byte frame.

Reset
REQ-025 On reset=0, immediately and without waiting for a clock edge:
  - state = INICIAL
  - tx_serial = 1, ocupado = 0, pronto_envio = 0, db_estado = 0
  - snapshot registers, checksum, byte index and bit/baud counters = 0
REQ-026 Reset asserted mid-frame SHALL abort the frame and leave tx_serial high; no partial resumption after release.
REQ-027 After reset release, the block SHALL wait in INICIAL for enviar_config.

Structure
REQ-028 A shared package SHALL hold:
  - FSM state encodings
  - HEADER default
  - frame length constant (12)
  - serial frame bit count (11)
REQ-029 Byte serialization SHALL live in one sub-module, tx_serial_8E1, with ports:
  - inputs: clock, reset, partida, dados[7:0]
  - outputs: saida_serial, pronto (one-cycle pulse)
  - CLKS_PER_BIT passed down from config_reporter.
REQ-030 config_reporter SHALL contain only the FSM, snapshot/checksum datapath, byte mux and index counter, with no second clock domain.

Verification (CLKS_PER_BIT=4)
REQ-031 Nominal report: limits umidade=0x0050, temp1=0x0019, temp2=0x001E, temp3=0x0023, temp4=0x0028; pulse enviar_config.
  - Decoded bytes: A5 00 50 00 19 00 1E 00 23 00 28 5C, all with even parity and stop bit = 1.
  - pronto_envio pulses once.
REQ-032 Snapshot hold: change temp_lim1_in to 0xFFFF during byte 2 -> frame still carries 00 19, checksum 5C.
REQ-033 Busy request: re-pulse enviar_config during byte 5 -> exactly 12 bytes sent and one pronto_envio pulse.
REQ-034 Reset mid-frame: assert reset during byte 7 -> in the same cycle tx_serial=1, ocupado=0, db_estado=0; after release, line stays idle with no enviar_config.
REQ-035 Back-to-back reports: hold enviar_config high continuously -> two or more complete frames.
  - Inter-byte gap of at most 2 cycles.
  - ocupado drops for exactly one cycle between frames.
REQ-036 Parity edge case: all limits 0xFFFF -> data bytes FF with parity bit 0, checksum 00 with parity bit 0.
